// File: rtl/fft16_pkg.sv
// Shared constants and the frame-controller state encoding for the FFT16 sequencer.
package fft16_pkg;

  localparam int FFT_N     = 16;
  localparam int FFT_W     = 32;
  localparam int FFT_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_UNLOAD = 2'd3
  } fft_state_e;

endpackage

// File: rtl/fft16_frame_buf.sv
// N x W sample register file: serial write port, whole frame visible as one flat vector.
module fft16_frame_buf
  import fft16_pkg::*;
#(
  parameter int N = FFT_N,
  parameter int W = FFT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [FFT_CNT_W-1:0] wr_idx,
  input  logic [W-1:0]         wr_data,
  output logic [N*W-1:0]       rd_flat
);

  logic [W-1:0] mem [N];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_flat
    assign rd_flat[k*W +: W] = mem[k];
  end

endmodule

// File: rtl/fft16_frame_ctrl.sv
// Frame sequencer for the FFT16 datapath: load 16 samples, launch, wait, unload 16 bins.
// Optional WAIT watchdog enabled by defining FFT16_FRAME_CTRL_TIMEOUT_EN.
module fft16_frame_ctrl
  import fft16_pkg::*;
#(
  parameter int N           = FFT_N,
  parameter int W           = FFT_W,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_data,
  output logic [N*W-1:0] fft_x,
  output logic           ab_valid,
  input  logic           fft_pe_valid,
  input  logic [N*W-1:0] fft_y,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic           out_last,
  output logic           busy,
  output logic           err_timeout
);

  localparam int CW = FFT_CNT_W;
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  if (N != FFT_N || W != FFT_W || TIMEOUT_CYC < 2) begin : g_bad_cfg
    $error("fft16_frame_ctrl: unsupported configuration");
  end

  fft_state_e     state;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  ocnt;
  logic [N*W-1:0] obuf;
  logic           in_ready_q;
  logic           wr_en;

  function automatic logic [W-1:0] pick_word(input logic [N*W-1:0] v,
                                             input logic [CW-1:0]  idx);
    return v[idx*W +: W];
  endfunction

  assign wr_en    = (state == ST_LOAD) && in_valid && in_ready_q;
  // in_ready must read 0 while reset is held even though its register resets to 1.
  assign in_ready = in_ready_q & rst;

  fft16_frame_buf #(.N(N), .W(W)) u_in_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_idx  (cnt),
    .wr_data (in_data),
    .rd_flat (fft_x)
  );

`ifdef FFT16_FRAME_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tcnt;
  logic          err_q;
  logic          expire;

  // tcnt equals the number of cycles since the LAUNCH cycle.
  assign expire      = (tcnt == TW'(TIMEOUT_CYC - 1));
  assign err_timeout = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tcnt  <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == ST_LAUNCH || state == ST_WAIT) tcnt <= tcnt + 1'b1;
      else                                        tcnt <= '0;
      if (state == ST_WAIT && !fft_pe_valid && expire) err_q <= 1'b1;
    end
  end
`else
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_LOAD;
      cnt        <= '0;
      ocnt       <= '0;
      obuf       <= '0;
      in_ready_q <= 1'b1;
      ab_valid   <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (wr_en) begin
            busy <= 1'b1;
            if (cnt == LAST_IDX) begin
              cnt        <= '0;
              in_ready_q <= 1'b0;
              ab_valid   <= 1'b1;
              state      <= ST_LAUNCH;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_LAUNCH: begin
          ab_valid <= 1'b0;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (fft_pe_valid) begin
            obuf      <= fft_y;
            out_data  <= fft_y[W-1:0];
            out_valid <= 1'b1;
            out_last  <= 1'b0;
            ocnt      <= '0;
            state     <= ST_UNLOAD;
          end
`ifdef FFT16_FRAME_CTRL_TIMEOUT_EN
          else if (expire) begin
            in_ready_q <= 1'b1;
            busy       <= 1'b0;
            state      <= ST_LOAD;
          end
`endif
        end
        ST_UNLOAD: begin
          if (out_ready) begin
            if (ocnt == LAST_IDX) begin
              ocnt       <= '0;
              out_valid  <= 1'b0;
              out_last   <= 1'b0;
              out_data   <= '0;
              in_ready_q <= 1'b1;
              busy       <= 1'b0;
              state      <= ST_LOAD;
            end else begin
              ocnt     <= ocnt + 1'b1;
              out_data <= pick_word(obuf, ocnt + 1'b1);
              out_last <= ((ocnt + 1'b1) == LAST_IDX);
            end
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_fft16_frame_ctrl.sv
// Randomised bench for fft16_frame_ctrl with a queue-based frame model and directed frames.
module tb_fft16_frame_ctrl;

  localparam int N = 16;
  localparam int W = 32;
  localparam int TIMEOUT_CYC = 64;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   in_data = '0;
  logic [N*W-1:0] fft_x;
  logic           ab_valid;
  logic           fft_pe_valid = 1'b0;
  logic [N*W-1:0] fft_y = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [W-1:0]   out_data;
  logic           out_last;
  logic           busy;
  logic           err_timeout;

  fft16_frame_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .fft_x(fft_x), .ab_valid(ab_valid), .fft_pe_valid(fft_pe_valid), .fft_y(fft_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- stimulus knobs and driver ----------------
  logic [32:0] src_q[$];   // bit 32 marks a one-cycle bubble
  int  p_in = 100, p_out = 100, out_mode = 0, pe_delay = 3, pe_en = 1, spur = 0, y_mode = 0;
  int  pe_cnt = 0, ocyc = 0;
  bit  acc_in, saw_ab;

  task automatic fill_y(input int mode);
    for (int k = 0; k < N; k++) begin
      case (mode)
        1:       fft_y[k*W +: W] = 32'h7FFF0000;
        2:       fft_y[k*W +: W] = 32'h100 + k;
        default: fft_y[k*W +: W] = $urandom();
      endcase
    end
  endtask

  always begin
    @(posedge clk);
    acc_in = in_valid && in_ready;
    saw_ab = ab_valid;
    #2;
    if (acc_in && src_q.size() > 0) void'(src_q.pop_front());
    if (src_q.size() > 0 && src_q[0][32]) begin
      in_valid = 1'b0;
      void'(src_q.pop_front());
    end else if (src_q.size() > 0) begin
      in_valid = ($urandom_range(99) < p_in);
      in_data  = src_q[0][31:0];
    end else begin
      in_valid = 1'b0;
    end
    ocyc++;
    out_ready = (out_mode != 0) ? ((ocyc % 4) == 0 || (ocyc % 4) == 3)
                                : ($urandom_range(99) < p_out);
    fft_pe_valid = 1'b0;
    if (saw_ab && pe_en != 0) pe_cnt = pe_delay;
    if (pe_cnt > 0) begin
      pe_cnt--;
      if (pe_cnt == 0) begin
        fft_pe_valid = 1'b1;
        fill_y(y_mode);
      end
    end else if (spur != 0 && $urandom_range(7) == 0) begin
      fft_pe_valid = 1'b1;
      fill_y(0);
    end
  end

  // ---------------- behavioural frame model ----------------
  int             m_phase;   // 0 collecting, 1 launching, 2 awaiting result, 3 draining
  int             m_cnt;
  logic [N*W-1:0] m_x;
  logic [W-1:0]   m_q[$];
  bit             m_err;
`ifdef FFT16_FRAME_CTRL_TIMEOUT_EN
  int             m_cyc = 0;
  int             m_launch = 0;
`endif

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase = 0; m_cnt = 0; m_x = '0; m_q.delete(); m_err = 1'b0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
          m_x[m_cnt*W +: W] = in_data;
          m_cnt++;
          if (m_cnt == N) begin m_cnt = 0; m_phase = 1; end
        end
        1: begin
          m_phase = 2;
`ifdef FFT16_FRAME_CTRL_TIMEOUT_EN
          m_launch = m_cyc;
`endif
        end
        2: begin
          if (fft_pe_valid) begin
            for (int k = 0; k < N; k++) m_q.push_back(fft_y[k*W +: W]);
            m_phase = 3;
          end
`ifdef FFT16_FRAME_CTRL_TIMEOUT_EN
          else if (m_cyc - m_launch == TIMEOUT_CYC - 1) begin
            m_err = 1'b1; m_phase = 0;
          end
`endif
        end
        3: if (out_ready) begin
          void'(m_q.pop_front());
          if (m_q.size() == 0) m_phase = 0;
        end
        default: m_phase = 0;
      endcase
`ifdef FFT16_FRAME_CTRL_TIMEOUT_EN
      m_cyc++;
`endif
    end
  end

  // ---------------- per-cycle comparison against the model ----------------
  always @(negedge clk) begin
    chk("in_ready", in_ready, rst && m_phase == 0);
    chk("ab_valid", ab_valid, m_phase == 1);
    chk("out_valid", out_valid, m_phase == 3);
    chk("busy", busy, !(m_phase == 0 && m_cnt == 0));
    chk("fft_x", fft_x, m_x);
    chk("err_timeout", err_timeout, m_err);
    if (m_phase == 3 && m_q.size() > 0) begin
      chk("out_data", out_data, m_q[0]);
      chk("out_last", out_last, m_q.size() == 1);
    end else begin
      chk("out_last_idle", out_last, 1'b0);
    end
  end

  // ---------------- observation monitor ----------------
  int             tcyc = 0, ab_cnt = 0, ab_cyc = 0, acc_n = 0, first_cyc = 0, acc16_cyc = 0;
  int             err_cyc = 0;
  bit             err_seen = 1'b0;
  logic [N*W-1:0] x_at_launch = '0;
  logic [W-1:0]   got_q[$];
  bit             last_q[$];

  always @(negedge clk) begin
    tcyc++;
    if (!rst) acc_n = 0;
    if (in_valid && in_ready) begin
      if (acc_n == 0) first_cyc = tcyc;
      acc_n++;
      if (acc_n == N) begin acc16_cyc = tcyc; acc_n = 0; end
    end
    if (ab_valid) begin ab_cnt++; ab_cyc = tcyc; x_at_launch = fft_x; end
    if (out_valid && out_ready) begin got_q.push_back(out_data); last_q.push_back(out_last); end
    if (err_timeout && !err_seen) begin err_seen = 1'b1; err_cyc = tcyc; end
  end

  task automatic wait_got(input int n, input string nm);
    int b = 0;
    while (got_q.size() < n && b < 3000) begin @(negedge clk); b++; end
    chk(nm, got_q.size() >= n, 1'b1);
  endtask

  task automatic wait_ab(input int prev, input string nm);
    int b = 0;
    while (ab_cnt <= prev && b < 500) begin @(negedge clk); b++; end
    chk(nm, ab_cnt > prev, 1'b1);
  endtask

  task automatic clear_obs();
    got_q.delete(); last_q.delete();
  endtask

  task automatic push_random(input int frames);
    for (int i = 0; i < frames * N; i++) src_q.push_back({1'b0, $urandom()});
  endtask

  int n0;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    @(posedge clk); #2 rst = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1'b1);

    // impulse frame
    clear_obs(); y_mode = 1; pe_delay = 3; p_in = 100; p_out = 100;
    n0 = ab_cnt;
    src_q.push_back({1'b0, 32'h7FFF0000});
    for (int i = 1; i < N; i++) src_q.push_back(33'h0);
    wait_ab(n0, "imp_launch");
    chk("imp_launch_lat", ab_cyc - acc16_cyc, 1);
    chk("imp_x0", x_at_launch[31:0], 32'h7FFF0000);
    chk("imp_xrest", x_at_launch[N*W-1:32], '0);
    wait_got(N, "imp_outputs");
    chk("imp_one_pulse", ab_cnt - n0, 1);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("imp_out%0d", k), got_q[k], 32'h7FFF0000);
      chk($sformatf("imp_last%0d", k), last_q[k], k == N - 1);
    end

    // ordering
    repeat (4) @(negedge clk);
    clear_obs(); y_mode = 2;
    n0 = ab_cnt;
    for (int k = 0; k < N; k++) src_q.push_back(33'(k));
    wait_ab(n0, "ord_launch");
    for (int k = 0; k < N; k++) chk($sformatf("ord_x%0d", k), x_at_launch[32*k +: 32], k);
    wait_got(N, "ord_outputs");
    for (int k = 0; k < N; k++) chk($sformatf("ord_out%0d", k), got_q[k], 32'h100 + k);

    // backpressure with a second frame queued behind
    repeat (4) @(negedge clk);
    clear_obs(); y_mode = 0; out_mode = 1;
    push_random(2);
    wait_got(2 * N, "bp_outputs");
    chk("bp_count", got_q.size(), 2 * N);
    out_mode = 0;

    // stall inside LOAD
    repeat (30) @(negedge clk);
    clear_obs(); p_out = 100;
    n0 = ab_cnt;
    for (int i = 0; i < 8; i++) src_q.push_back({1'b0, $urandom()});
    for (int i = 0; i < 10; i++) src_q.push_back({1'b1, 32'h0});
    for (int i = 0; i < 8; i++) src_q.push_back({1'b0, $urandom()});
    wait_ab(n0, "stall_launch");
    chk("stall_span", ab_cyc - first_cyc, 26);
    chk("stall_last_lat", ab_cyc - acc16_cyc, 1);
    wait_got(N, "stall_outputs");

    // randomised frames with spurious result strobes
    repeat (4) @(negedge clk);
    clear_obs(); p_in = 70; p_out = 60; pe_delay = 1 + $urandom_range(7); spur = 1;
    push_random(6);
    wait_got(6 * N, "rand_outputs");
    spur = 0; p_in = 100; p_out = 100;

    // reset during WAIT, then a stale result strobe
    repeat (20) @(negedge clk);
    clear_obs(); pe_delay = 20;
    n0 = ab_cnt;
    push_random(1);
    wait_ab(n0, "rw_launch");
    @(posedge clk); #3 rst = 1'b0;
    #1;
    chk("rw_in_ready", in_ready, 1'b0);
    chk("rw_ab_valid", ab_valid, 1'b0);
    chk("rw_out_valid", out_valid, 1'b0);
    chk("rw_out_last", out_last, 1'b0);
    chk("rw_out_data", out_data, '0);
    chk("rw_busy", busy, 1'b0);
    chk("rw_fft_x", fft_x, '0);
    chk("rw_err", err_timeout, 1'b0);
    repeat (2) @(posedge clk); #2 rst = 1'b1;
    repeat (30) @(negedge clk);
    chk("rw_stale_ignored", got_q.size(), 0);
    chk("rw_in_ready_after", in_ready, 1'b1);
    pe_delay = 3;

`ifdef FFT16_FRAME_CTRL_TIMEOUT_EN
    clear_obs(); pe_en = 0;
    n0 = ab_cnt;
    push_random(1);
    wait_ab(n0, "to_launch");
    begin
      int b = 0;
      while (!err_seen && b < 200) begin @(negedge clk); b++; end
    end
    chk("to_raised", err_seen, 1'b1);
    chk("to_latency", err_cyc - ab_cyc, TIMEOUT_CYC);
    pe_en = 1;
    repeat (3) @(negedge clk);
    push_random(1);
    wait_got(N, "to_next_frame");
    chk("to_sticky", err_timeout, 1'b1);
`endif

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
